mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port RAM
// with a fixed read latency.
//
// Parameters
//   WAIT_CYCLES : RAM read latency in cycles after the enable cycle (1..15)
//
// Ports
//   clk, reset                      : clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0           : requester 0 (instruction fetch)
//   req1/we1/addr1/wdata1           : requester 1 (data access)
//   ack0, ack1                      : one-cycle completion pulse to the owner
//   rdata                           : registered read data, held until next read
//   busy                            : high whenever the FSM is not idle
//   ram_en, ram_we                  : RAM access / write strobes
//   ram_addr, ram_wdata, ram_rdata  : RAM address / write data / read data
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [15:0] addr0,
  input  logic [15:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        owner;
  logic        last_grant;   // 1 after reset so that requester 0 wins a tie
  logic        grant_valid;
  logic        grant_id;
  logic        capture_rd;

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = 1'b0;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_nxt   = WAIT_LOAD;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign capture_rd = (state == ST_WAIT) && (cnt == 4'd1) && !lat_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rdata      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && grant_valid) begin
        owner      <= grant_id;
        last_grant <= grant_id;
        lat_we     <= grant_id ? we1    : we0;
        lat_addr   <= grant_id ? addr1  : addr0;
        lat_wdata  <= grant_id ? wdata1 : wdata0;
      end
      if (capture_rd) begin
        rdata <= ram_rdata;
      end
    end
  end

  // All outputs decode registered state only; req never reaches the strobes.
  assign busy      = (state != ST_IDLE);
  assign ram_en    = (state == ST_ACCESS);
  assign ram_we    = (state == ST_ACCESS) && lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign ack0      = (state == ST_DONE) && !owner;
  assign ack1      = (state == ST_DONE) && owner;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, busy, ram_en, ram_we;
  logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata;

  // Secondary instances for latency at the parameter extremes
  logic        l1_req, l1_ack0, l1_ack1, l1_busy, l1_en, l1_we;
  logic [15:0] l1_rdata, l1_addr, l1_wdata, l1_ram_rdata;
  logic        l15_req, l15_ack0, l15_ack1, l15_busy, l15_en, l15_we;
  logic [15:0] l15_rdata, l15_addr, l15_wdata, l15_ram_rdata;
  logic [15:0] laddr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        id;
    logic        rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .req0(l1_req), .we0(1'b0), .addr0(laddr), .wdata0(16'h0000),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .wdata1(16'h0000),
    .ack0(l1_ack0), .ack1(l1_ack1), .rdata(l1_rdata), .busy(l1_busy),
    .ram_en(l1_en), .ram_we(l1_we), .ram_addr(l1_addr),
    .ram_wdata(l1_wdata), .ram_rdata(l1_ram_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .reset(reset),
    .req0(l15_req), .we0(1'b0), .addr0(laddr), .wdata0(16'h0000),
    .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .wdata1(16'h0000),
    .ack0(l15_ack0), .ack1(l15_ack1), .rdata(l15_rdata), .busy(l15_busy),
    .ram_en(l15_en), .ram_we(l15_we), .ram_addr(l15_addr),
    .ram_wdata(l15_wdata), .ram_rdata(l15_ram_rdata)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    pat = (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hC3A5);
  endfunction

  // RAM models: read data is only valid in the last WAIT cycle (age == latency)
  logic [15:0]  mem [0:255];
  logic [255:0] wvalid;
  int           age_m, age_1, age_15;
  logic [15:0]  rd_m, rd_1, rd_15;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age_m  <= 0;
      rd_m   <= 16'h0000;
      wvalid <= '0;
    end else if (ram_en) begin
      age_m <= 1;
      if (ram_we) begin
        mem[ram_addr[7:0]]    <= ram_wdata;
        wvalid[ram_addr[7:0]] <= 1'b1;
      end else begin
        rd_m <= wvalid[ram_addr[7:0]] ? mem[ram_addr[7:0]] : pat(ram_addr);
      end
    end else if (age_m != 0) begin
      age_m <= age_m + 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age_1  <= 0;
      age_15 <= 0;
      rd_1   <= 16'h0000;
      rd_15  <= 16'h0000;
    end else begin
      if (l1_en) begin
        age_1 <= 1;
        rd_1  <= pat(l1_addr);
      end else if (age_1 != 0) begin
        age_1 <= age_1 + 1;
      end
      if (l15_en) begin
        age_15 <= 1;
        rd_15  <= pat(l15_addr);
      end else if (age_15 != 0) begin
        age_15 <= age_15 + 1;
      end
    end
  end

  assign ram_rdata     = (age_m == 2)   ? rd_m  : 16'hDEAD;
  assign l1_ram_rdata  = (age_1 == 1)   ? rd_1  : 16'hDEAD;
  assign l15_ram_rdata = (age_15 == 15) ? rd_15 : 16'hDEAD;

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if ({busy, ack0, ack1, ram_en, ram_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy/ack0/ack1/en/we=%b expected 00000",
               {busy, ack0, ack1, ram_en, ram_we});
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rdata: got %h expected 0000", rdata);
    end
    total++;
    if ({ram_addr, ram_wdata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_ram_bus: addr/wdata=%h/%h expected 0000/0000", ram_addr, ram_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    exp_t e;
    int   n;
    int   en_cnt = 0;
    logic seen = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    sb.push_back(exp_t'({1'b0, 1'b1, 16'hBEEF}));
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ram_en) begin
        en_cnt++;
        total++;
        if ({ram_we, ram_addr} !== {1'b0, 16'h0010}) begin
          bad++;
          $display("FAIL read_access: we/addr=%b/%h expected 0/0010", ram_we, ram_addr);
        end
        addr0 = 16'hFFFF;  // must not disturb the access in flight
      end
      if (ack0 || ack1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || n != 4) begin
      bad++;
      $display("FAIL read_latency: seen=%0d cycles=%0d expected 4", seen, n);
    end
    total++;
    if ({ack0, ack1} !== 2'b10) begin
      bad++;
      $display("FAIL read_ack: ack0/ack1=%b expected 10", {ack0, ack1});
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL read_sb: scoreboard empty got rdata %h", rdata);
    end else begin
      e = sb.pop_front();
      if (rdata !== e.data) begin
        bad++;
        $display("FAIL read_data: got %h expected %h", rdata, e.data);
      end
    end
    total++;
    if (en_cnt != 1) begin
      bad++;
      $display("FAIL read_en_count: got %0d expected 1", en_cnt);
    end
    req0 = 1'b0;
    addr0 = 16'h0000;
    @(negedge clk);
    total++;
    if ({busy, ack0, ack1} !== 3'b000 || rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_hold: busy/acks=%b rdata=%h expected 000/BEEF",
               {busy, ack0, ack1}, rdata);
    end
  endtask

  task automatic test_write();
    exp_t        e;
    int          n;
    logic        seen = 1'b0;
    logic [15:0] old = rdata;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h00A0; wdata1 = 16'h1234;
    sb.push_back(exp_t'({1'b1, 1'b0, 16'h0000}));
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ram_en) begin
        total++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h00A0, 16'h1234}) begin
          bad++;
          $display("FAIL write_access: we/addr/wdata=%b/%h/%h expected 1/00A0/1234",
                   ram_we, ram_addr, ram_wdata);
        end
        wdata1 = 16'h5555;
        we1    = 1'b0;
      end
      if (ack0 || ack1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || sb.size() == 0) begin
      bad++;
      $display("FAIL write_ack: seen=%0d sb=%0d expected ack1", seen, sb.size());
    end else begin
      e = sb.pop_front();
      if ({ack0, ack1} !== {~e.id, e.id} || n != 4) begin
        bad++;
        $display("FAIL write_ack: ack0/ack1=%b cycles=%0d expected %b/4",
                 {ack0, ack1}, n, {~e.id, e.id});
      end
    end
    total++;
    if (rdata !== old) begin
      bad++;
      $display("FAIL write_rdata: got %h expected unchanged %h", rdata, old);
    end
    total++;
    if (mem[8'hA0] !== 16'h1234 || ram_addr !== 16'h00A0 || ram_wdata !== 16'h1234) begin
      bad++;
      $display("FAIL write_mem: mem=%h addr=%h wdata=%h expected 1234/00A0/1234",
               mem[8'hA0], ram_addr, ram_wdata);
    end
    req1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_both();
    exp_t e;
    int   acks = 0;
    int   en_cnt = 0;
    pulse_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0030;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0031;
    sb.push_back(exp_t'({1'b0, 1'b1, pat(16'h0030)}));
    sb.push_back(exp_t'({1'b1, 1'b1, pat(16'h0031)}));
    for (int n = 1; n <= 40 && acks < 2; n++) begin
      @(negedge clk);
      if (ram_en) en_cnt++;
      if (ack0 || ack1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL both_sb: unexpected ack0/ack1=%b", {ack0, ack1});
        end else begin
          e = sb.pop_front();
          if ({ack0, ack1} !== {~e.id, e.id} || rdata !== e.data || en_cnt != 1) begin
            bad++;
            $display("FAIL both_order: ack0/ack1=%b rdata=%h en=%0d expected %b/%h/1",
                     {ack0, ack1}, rdata, en_cnt, {~e.id, e.id}, e.data);
          end
        end
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
        en_cnt = 0;
        acks++;
      end
    end
    total++;
    if (acks != 2) begin
      bad++;
      $display("FAIL both_count: got %0d acks expected 2", acks);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   acks = 0;
    int   idle = 0;
    int   en_cnt = 0;
    pulse_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0033;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0044;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb.push_back(exp_t'({1'b0, 1'b1, pat(16'h0033)}));
      else            sb.push_back(exp_t'({1'b1, 1'b1, pat(16'h0044)}));
    end
    for (int n = 1; n <= 80 && acks < 6; n++) begin
      @(negedge clk);
      if (!busy) idle++;
      if (ram_en) en_cnt++;
      if (ack0 || ack1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL b2b_sb: unexpected ack0/ack1=%b", {ack0, ack1});
        end else begin
          e = sb.pop_front();
          if ({ack0, ack1} !== {~e.id, e.id} || rdata !== e.data || en_cnt != 1) begin
            bad++;
            $display("FAIL b2b_order: txn %0d ack0/ack1=%b rdata=%h en=%0d expected %b/%h/1",
                     acks, {ack0, ack1}, rdata, en_cnt, {~e.id, e.id}, e.data);
          end
        end
        if (acks > 0) begin
          total++;
          if (idle != 1) begin
            bad++;
            $display("FAIL b2b_idle: txn %0d idle cycles=%0d expected 1", acks, idle);
          end
        end
        idle = 0;
        en_cnt = 0;
        acks++;
        if (acks == 6) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    total++;
    if (acks != 6) begin
      bad++;
      $display("FAIL b2b_count: got %0d acks expected 6", acks);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    logic seen = 1'b0;
    logic stray = 1'b0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    for (n = 1; n <= 20 && !ram_en; n++) @(negedge clk);
    @(negedge clk);  // first WAIT cycle
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, ram_en, ack0, ack1} !== 4'b0 || rdata !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_state: busy/en/ack0/ack1=%b rdata=%h expected 0000/0000",
               {busy, ram_en, ack0, ack1}, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) stray = 1'b1;
    end
    req0 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    if (ack0 || ack1 || busy) stray = 1'b1;
    total++;
    if (stray) begin
      bad++;
      $display("FAIL midrst_noack: activity seen=%0d expected 0", stray);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
    sb.push_back(exp_t'({1'b1, 1'b1, pat(16'h0040)}));
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || sb.size() == 0) begin
      bad++;
      $display("FAIL midrst_next: seen=%0d sb=%0d expected ack1", seen, sb.size());
    end else begin
      e = sb.pop_front();
      if ({ack0, ack1} !== {~e.id, e.id} || rdata !== e.data || n != 4) begin
        bad++;
        $display("FAIL midrst_next: ack0/ack1=%b rdata=%h cycles=%0d expected %b/%h/4",
                 {ack0, ack1}, rdata, n, {~e.id, e.id}, e.data);
      end
    end
    req1 = 1'b0;
  endtask

  task automatic test_latency();
    int   lat1 = 0;
    int   lat15 = 0;
    logic [15:0] d1 = 16'h0000;
    logic [15:0] d15 = 16'h0000;
    @(negedge clk);
    laddr = 16'h0055;
    l1_req = 1'b1;
    l15_req = 1'b1;
    for (int n = 1; n <= 30 && (lat1 == 0 || lat15 == 0); n++) begin
      @(negedge clk);
      if ((l1_ack0 || l1_ack1) && lat1 == 0) begin
        lat1 = n;
        d1 = l1_rdata;
        l1_req = 1'b0;
      end
      if ((l15_ack0 || l15_ack1) && lat15 == 0) begin
        lat15 = n;
        d15 = l15_rdata;
        l15_req = 1'b0;
      end
    end
    l1_req = 1'b0;
    l15_req = 1'b0;
    total++;
    if (lat1 != 3) begin
      bad++;
      $display("FAIL lat_w1: got %0d cycles expected 3", lat1);
    end
    total++;
    if (d1 !== pat(16'h0055)) begin
      bad++;
      $display("FAIL lat_w1_data: got %h expected %h", d1, pat(16'h0055));
    end
    total++;
    if (lat15 != 17) begin
      bad++;
      $display("FAIL lat_w15: got %0d cycles expected 17", lat15);
    end
    total++;
    if (d15 !== pat(16'h0055)) begin
      bad++;
      $display("FAIL lat_w15_data: got %h expected %h", d15, pat(16'h0055));
    end
  endtask

  initial begin
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    l1_req = 1'b0; l15_req = 1'b0; laddr = '0;
    test_reset();
    test_read();
    test_write();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
